// File: rtl/vn_serial.sv
// Serial variable-node processor for a min-sum LDPC decoder.
// Takes the channel LLR and DV check messages, then streams back DV saturated extrinsic messages and a hard decision.
module vn_serial #(
  parameter int WIDTH = 20,
  parameter int DV    = 3,
  localparam int IDXW = (DV > 1) ? $clog2(DV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             hard_bit,
  output logic             hard_valid
);

  localparam int SW = WIDTH + $clog2(DV + 1) + 1;
  localparam int CW = $clog2(DV + 1);
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic signed [SW-1:0]  total_reg;
  logic [WIDTH-1:0]      msg_reg [DV];
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [WIDTH-1:0]      out_data_reg;
  logic [IDXW-1:0]       out_idx_reg;
  logic                  out_last_reg;
  logic                  hard_bit_reg;
  logic                  hard_valid_reg;

  logic                  in_fire;
  logic                  out_fire;
  logic signed [SW-1:0]  total_new;
  logic [WIDTH-1:0]      first_msg;
  logic [IDXW-1:0]       nxt_idx;
  logic [IDXW-1:0]       wr_idx;
  logic [WIDTH-1:0]      nxt_msg;

  function automatic logic signed [SW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(SW - WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Symmetric clamp: the most negative code is never produced on the output.
  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  assign in_fire   = in_valid && in_ready_reg;
  assign out_fire  = out_valid_reg && out_ready;
  assign total_new = total_reg + sext(in_data);
  assign wr_idx    = IDXW'(cnt_reg - CW'(1));
  assign nxt_idx   = out_idx_reg + IDXW'(1);
  // With DV==1 the only message arrives on the same beat that ends accumulation.
  assign first_msg = (DV == 1) ? in_data : msg_reg[0];

  always_comb begin
    nxt_msg = '0;
    for (int i = 0; i < DV; i++) begin
      if (nxt_idx == IDXW'(i)) nxt_msg = msg_reg[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      total_reg      <= '0;
      for (int i = 0; i < DV; i++) msg_reg[i] <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_idx_reg    <= '0;
      out_last_reg   <= 1'b0;
      hard_bit_reg   <= 1'b0;
      hard_valid_reg <= 1'b0;
    end else begin
      hard_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_fire) begin
            total_reg <= sext(in_data);
            cnt_reg   <= CW'(1);
            state_reg <= ACC;
          end
        end
        ACC: begin
          if (in_fire) begin
            msg_reg[wr_idx] <= in_data;
            total_reg       <= total_new;
            cnt_reg         <= cnt_reg + CW'(1);
            if (cnt_reg == CW'(DV)) begin
              state_reg      <= OUT;
              in_ready_reg   <= 1'b0;
              out_valid_reg  <= 1'b1;
              out_idx_reg    <= '0;
              out_last_reg   <= (DV == 1);
              out_data_reg   <= sat(total_new - sext(first_msg));
              hard_bit_reg   <= total_new[SW-1];
              hard_valid_reg <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            if (out_idx_reg == IDXW'(DV - 1)) begin
              state_reg     <= IDLE;
              in_ready_reg  <= 1'b1;
              out_valid_reg <= 1'b0;
              out_idx_reg   <= '0;
              out_last_reg  <= 1'b0;
              out_data_reg  <= '0;
              cnt_reg       <= '0;
            end else begin
              // Next message is precomputed so out_data stays a pure register.
              out_idx_reg  <= nxt_idx;
              out_last_reg <= (nxt_idx == IDXW'(DV - 1));
              out_data_reg <= sat(total_reg - sext(nxt_msg));
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_idx    = out_idx_reg;
  assign out_last   = out_last_reg;
  assign hard_bit   = hard_bit_reg;
  assign hard_valid = hard_valid_reg;

endmodule

// File: tb/tb_vn_serial.sv
// Randomized self-checking bench for vn_serial (WIDTH=8, DV=3) against an arithmetic reference model.
module tb_vn_serial;

  localparam int W  = 8;
  localparam int DV = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         hard_bit;
  logic         hard_valid;

  vn_serial #(.WIDTH(W), .DV(DV)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .hard_bit  (hard_bit),
    .hard_valid(hard_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hv_count = 0;
  bit prev_hv = 1'b0;
  int exp_d_q[$];
  int exp_i_q[$];
  int exp_h_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int rnd8();
    logic [7:0] r;
    r = 8'($urandom);
    return int'($signed(r));
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_out_data"},   out_data,   0);
    chk({tag, "_out_idx"},    out_idx,    0);
    chk({tag, "_out_last"},   out_last,   0);
    chk({tag, "_hard_bit"},   hard_bit,   0);
    chk({tag, "_hard_valid"}, hard_valid, 0);
  endtask

  // Output and hard-decision monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_d_q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          int d;
          int i;
          d = exp_d_q.pop_front();
          i = exp_i_q.pop_front();
          $display("OUT idx=%0d data=%0d last=%0d expect idx=%0d data=%0d",
                   out_idx, $signed(out_data), out_last, i, d);
          chk("out_data", int'($signed(out_data)), d);
          chk("out_idx", out_idx, i);
          chk("out_last", out_last, (i == DV - 1) ? 1 : 0);
        end
      end
      if (hard_valid) begin
        hv_count++;
        chk("hard_valid_width", prev_hv, 0);
        if (exp_h_q.size() == 0) chk("hard_unexpected", 1, 0);
        else chk("hard_bit", hard_bit, exp_h_q.pop_front());
      end
    end
    prev_hv = hard_valid;
  end

  // One node: DV+1 input beats (optional gaps), then DV output beats with optional stall or reset abort.
  task automatic run_node(input int llr, input int m0, input int m1, input int m2,
                          input int gap_max, input int bp_idx, input int bp_len,
                          input int abort_idx, output int t0);
    int m[3];
    int vals[4];
    int tot;
    int sd;
    m    = '{m0, m1, m2};
    vals = '{llr, m0, m1, m2};
    tot  = llr + m0 + m1 + m2;
    t0   = 0;
    $display("NODE llr=%0d msgs=%0d,%0d,%0d total=%0d", llr, m0, m1, m2, tot);
    for (int k = 0; k < DV; k++) begin
      exp_d_q.push_back(clamp(tot - m[k]));
      exp_i_q.push_back(k);
    end
    exp_h_q.push_back((tot < 0) ? 1 : 0);

    for (int b = 0; b <= DV; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = W'(vals[b]);
      @(negedge clk);
      chk("in_ready_accept", in_ready, 1);
      @(posedge clk); #1;
      if (b == 0) t0 = cyc;
      in_valid = 1'b0;
    end

    chk("latency_out_valid", out_valid, 1);
    for (int k = 0; k < DV; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      if (k == abort_idx) begin
        out_ready = 1'b0;
        chk("abort_idx", out_idx, k);
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        exp_d_q.delete();
        exp_i_q.delete();
        exp_h_q.delete();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (k == bp_idx) begin
        out_ready = 1'b0;
        sd = int'(out_data);
        repeat (bp_len) begin
          @(negedge clk);
          chk("bp_out_data", out_data, sd);
          chk("bp_out_idx", out_idx, k);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("out_valid_hold", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int ts[4];
    int hv0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset_release");

    // Directed cases
    run_node(10, 5, -3, 7, 0, -1, 0, -1, t);
    run_node(-50, -1, -1, -1, 0, -1, 0, -1, t);
    run_node(100, 100, 100, -128, 0, -1, 0, -1, t);
    run_node(-128, -128, -128, -128, 0, -1, 0, -1, t);
    run_node(10, 5, -3, 7, 0, 1, 5, -1, t);
    run_node(10, 5, -3, 7, 3, -1, 0, -1, t);
    run_node(20, 1, 2, 3, 0, -1, 0, 1, t);
    run_node(10, 5, -3, 7, 0, -1, 0, -1, t);
    run_node(0, 0, 0, 0, 0, -1, 0, -1, t);

    // Back-to-back throughput
    hv0 = hv_count;
    for (int n = 0; n < 4; n++) run_node(rnd8(), rnd8(), rnd8(), rnd8(), 0, -1, 0, -1, ts[n]);
    for (int n = 1; n < 4; n++) chk("node_period", ts[n] - ts[n-1], 2 * DV + 1);
    chk("hard_valid_per_node", hv_count - hv0, 4);

    // Random nodes with random gaps and stalls
    for (int n = 0; n < 40; n++) begin
      run_node(rnd8(), rnd8(), rnd8(), rnd8(), $urandom_range(0, 2),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DV - 1)) : -1,
               $urandom_range(1, 4), -1, t);
    end

    @(negedge clk);
    chk("leftover_outputs", exp_d_q.size(), 0);
    chk("leftover_hard", exp_h_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
